// File: rtl/ts_pkg.sv
// ts_pkg: shared constants and FSM state type for the MPEG-2 TS packet stamper.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int          TS_PKT_LEN   = 188;
  localparam int          TS_HDR_LEN   = 4;
  localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

  // State names the byte currently held in the output register.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    H0   = 3'd1,
    H1   = 3'd2,
    H2   = 3'd3,
    H3   = 3'd4,
    PAY  = 3'd5
  } ts_state_t;

endpackage

// File: rtl/ts_cc_table.sv
// ts_cc_table: NUM_CH independent 4-bit continuity counters.
// The counter selected by idx is read combinationally and advanced by
// step (1 or 2, wrapping mod 16) when inc is high.
module ts_cc_table #(
  parameter int NUM_CH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            idx,
  input  logic                  inc,
  input  logic [1:0]            step,
  output logic [3:0]            cc,
  output logic [4*NUM_CH-1:0]   cc_state
);

  logic [3:0] cnt [NUM_CH];

  // Per-channel counters; only the indexed channel moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= 4'h0;
    end else if (inc) begin
      cnt[idx] <= cnt[idx] + {2'b00, step};
    end
  end

  assign cc = cnt[idx];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign cc_state[4*g +: 4] = cnt[g];
  end

endmodule

// File: rtl/ts_cc_stamper.sv
// ts_cc_stamper: builds 188-byte MPEG-2 TS packets from a payload byte stream,
// stamping sync byte, PID, PUSI and a per-channel continuity counter.
// Optional feature macro: TS_CC_ERR_INJECT_EN (cc_skip forces one missing CC).
//
// Handshakes: a byte moves on ts_data when ts_valid & ts_ready at the rising
// edge, and a payload byte is taken when pl_valid & pl_ready at the rising
// edge. Once ts_valid is high it stays high with ts_data frozen until taken.
// fsm_state exposes the FSM for observation.
module ts_cc_stamper
  import ts_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PKT_LEN = TS_PKT_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          chan,
  input  logic [12:0]         pid,
  input  logic                pusi,
  input  logic                cc_skip,
  input  logic [7:0]          pl_data,
  input  logic                pl_valid,
  output logic                pl_ready,
  output logic [7:0]          ts_data,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic                ts_sync,
  output logic                busy,
  output logic [4*NUM_CH-1:0] cc_state,
  output ts_state_t           fsm_state
);

  localparam logic [7:0] PAY_LAST = 8'(PKT_LEN - TS_HDR_LEN);

  ts_state_t   state;
  logic [1:0]  chan_l;
  logic [12:0] pid_l;
  logic        pusi_l;
  logic [7:0]  pay_cnt;
  logic        skip_eff;
  logic        null_pkt;
  logic [3:0]  cc_rd;
  logic [3:0]  cc_field;
  logic        out_hs;
  logic        out_free;
  logic        pl_hs;
  logic        req_ok;

  assign out_hs   = ts_valid & ts_ready;
  assign out_free = ~ts_valid | ts_ready;
  assign req_ok   = start & (32'(chan) < NUM_CH);
  assign null_pkt = (pid_l == TS_NULL_PID);

`ifdef TS_CC_ERR_INJECT_EN
  logic skip_l;

  // Latch the error-inject request together with the packet request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) skip_l <= 1'b0;
    else if (state == IDLE && req_ok) skip_l <= cc_skip;
  end

  assign skip_eff = skip_l & ~null_pkt;
`else
  logic unused_skip;
  assign unused_skip = cc_skip;
  assign skip_eff    = 1'b0;
`endif

  // Null packets carry CC 0 and never touch their channel counter.
  assign cc_field = null_pkt ? 4'h0 : (cc_rd + {3'b000, skip_eff});

  ts_cc_table #(.NUM_CH(NUM_CH)) u_cc_table (
    .clk      (clk),
    .rst      (rst),
    .idx      (chan_l),
    .inc      ((state == H3) & out_hs & ~null_pkt),
    .step     (skip_eff ? 2'd2 : 2'd1),
    .cc       (cc_rd),
    .cc_state (cc_state)
  );

  // Payload fetch opens on the H3 handshake cycle so the first payload byte
  // follows the header with no bubble; it closes once all payload is taken.
  assign pl_ready = ((state == H3) | ((state == PAY) & (pay_cnt != PAY_LAST))) & out_free;
  assign pl_hs    = pl_valid & pl_ready;
  assign busy     = (state != IDLE);
  assign fsm_state = state;

  // Packet FSM and the single output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      chan_l   <= 2'd0;
      pid_l    <= 13'd0;
      pusi_l   <= 1'b0;
      pay_cnt  <= 8'd0;
      ts_data  <= 8'h00;
      ts_valid <= 1'b0;
      ts_sync  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            chan_l   <= chan;
            pid_l    <= pid;
            pusi_l   <= pusi;
            pay_cnt  <= 8'd0;
            ts_data  <= TS_SYNC_BYTE;
            ts_valid <= 1'b1;
            ts_sync  <= 1'b1;
            state    <= H0;
          end
        end
        H0: begin
          if (out_hs) begin
            ts_data <= {1'b0, pusi_l, 1'b0, pid_l[12:8]};
            ts_sync <= 1'b0;
            state   <= H1;
          end
        end
        H1: begin
          if (out_hs) begin
            ts_data <= pid_l[7:0];
            state   <= H2;
          end
        end
        H2: begin
          if (out_hs) begin
            ts_data <= {2'b00, 2'b01, cc_field};
            state   <= H3;
          end
        end
        H3: begin
          if (out_hs) begin
            state <= PAY;
            if (pl_hs) begin
              ts_data <= pl_data;
              pay_cnt <= 8'd1;
            end else begin
              ts_valid <= 1'b0;
              pay_cnt  <= 8'd0;
            end
          end
        end
        PAY: begin
          if (pl_hs) begin
            ts_data  <= pl_data;
            ts_valid <= 1'b1;
            pay_cnt  <= pay_cnt + 8'd1;
          end else if (out_hs) begin
            ts_valid <= 1'b0;
            if (pay_cnt == PAY_LAST) state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          ts_valid <= 1'b0;
          ts_sync  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_cc_stamper.sv
// tb_ts_cc_stamper: scoreboard bench for ts_cc_stamper. Expected packet bytes
// are pushed when a request is driven and popped as bytes leave the DUT.
module tb_ts_cc_stamper;
  import ts_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [1:0]  chan;
  logic [12:0] pid;
  logic        pusi;
  logic        cc_skip;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  ts_data;
  logic        ts_valid;
  logic        ts_ready;
  logic        ts_sync;
  logic        busy;
  logic [15:0] cc_state;
  ts_state_t   fsm_state;

  ts_cc_stamper dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .chan      (chan),
    .pid       (pid),
    .pusi      (pusi),
    .cc_skip   (cc_skip),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_sync   (ts_sync),
    .busy      (busy),
    .cc_state  (cc_state),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];
  logic [3:0]  model_cc[4];
  bit          stall_mode = 1'b0;
  bit          noise_mode = 1'b0;
  int          pl_seq = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_flat();
    return {model_cc[3], model_cc[2], model_cc[1], model_cc[0]};
  endfunction

  // ---------------- driver: downstream ready and payload source ----------------
  always @(posedge clk) begin
    #1;
    ts_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    pl_valid = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    pl_data  = pl_valid ? 8'(pl_seq) : 8'($urandom_range(0, 255));
  end

  // ---------------- monitor: sample mid-cycle, compare against queue ----------------
  logic       prev_pend = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      pl_seq    = 0;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check_eq("hold_valid", 32'(ts_valid), 32'd1);
        check_eq("hold_data", 32'(ts_data), 32'(prev_data));
      end
      if (ts_valid && ts_ready) begin
        if (exp_q.size() == 0) check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
        else check_eq("ts_byte", 32'({ts_sync, ts_data}), 32'(exp_q.pop_front()));
      end
      if (pl_valid && pl_ready) pl_seq = (pl_seq == 183) ? 0 : pl_seq + 1;
      prev_pend = ts_valid && !ts_ready;
      prev_data = ts_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic queue_pkt(input logic [1:0] ch, input logic [12:0] p, input logic pu, input logic sk);
    logic       eff;
    logic       is_null;
    logic [3:0] ccv;
    is_null = (p == 13'h1FFF);
    eff = 1'b0;
`ifdef TS_CC_ERR_INJECT_EN
    eff = sk && !is_null;
`else
    eff = 1'b0 & sk;
`endif
    ccv = is_null ? 4'h0 : model_cc[ch] + {3'b000, eff};
    exp_q.push_back({1'b1, 8'h47});
    exp_q.push_back({1'b0, 1'b0, pu, 1'b0, p[12:8]});
    exp_q.push_back({1'b0, p[7:0]});
    exp_q.push_back({1'b0, 4'h1, ccv});
    for (int i = 0; i < 184; i++) exp_q.push_back({1'b0, 8'(i)});
    if (!is_null) model_cc[ch] = model_cc[ch] + (eff ? 4'd2 : 4'd1);
  endtask

  task automatic send_pkt(input logic [1:0] ch, input logic [12:0] p, input logic pu, input logic sk);
    int w;
    int cyc;
    w = 0;
    while (busy && w < 2000) begin
      @(posedge clk); #1; w++;
    end
    check_eq("idle_wait", 32'(busy), 32'd0);
    queue_pkt(ch, p, pu, sk);
    start = 1'b1; chan = ch; pid = p; pusi = pu; cc_skip = sk;
    @(posedge clk); #1;
    start = 1'b0; cc_skip = 1'b0;
    check_eq("start_lat", 32'({busy, ts_valid, ts_sync, ts_data}), 32'({3'b111, 8'h47}));
    cyc = 0;
    while (busy && cyc < 5000) begin
      if (noise_mode && $urandom_range(0, 7) == 0) begin
        start = 1'b1; chan = 2'($urandom_range(0, 3)); pid = 13'h0AA;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end
    check_eq("busy_drop", 32'(busy), 32'd0);
    if (!stall_mode) begin
      check_eq("pkt_cycles", 32'(cyc), 32'd188);
      check_eq("gap_idle", 32'(ts_valid), 32'd0);
    end
    check_eq("q_drain", 32'(exp_q.size()), 32'd0);
    check_eq("cc_state", 32'(cc_state), 32'(model_flat()));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] exp_c3;
    int w;
    rst = 1'b0; start = 1'b0; chan = 2'd0; pid = 13'd0; pusi = 1'b0; cc_skip = 1'b0;
    ts_ready = 1'b1; pl_valid = 1'b1; pl_data = 8'h00;
    for (int i = 0; i < 4; i++) model_cc[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ts_data", 32'(ts_data), 32'h00);
    check_eq("rst_ts_valid", 32'(ts_valid), 32'd0);
    check_eq("rst_ts_sync", 32'(ts_sync), 32'd0);
    check_eq("rst_pl_ready", 32'(pl_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cc_state", 32'(cc_state), 32'd0);
    check_eq("rst_fsm", 32'(fsm_state), 32'(IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back full-rate packets on channel 0: headers 47 41 00 1x.
    for (int k = 0; k < 4; k++) send_pkt(2'd0, 13'h100, 1'b1, 1'b0);

    // 17 packets on channel 2 walk the counter through a full wrap.
    for (int k = 0; k < 17; k++) send_pkt(2'd2, 13'(13'h0200 + k), 1'(k), 1'b0);
    check_eq("chan2_wrap", 32'(cc_state[11:8]), 32'd1);

    // Random stalls on both sides plus ignored start pulses while busy.
    stall_mode = 1'b1;
    noise_mode = 1'b1;
    for (int k = 0; k < 4; k++) send_pkt(2'd1, 13'h055, 1'b0, 1'b0);

    // Null packets between channel 1 packets CC 4 and 5.
    send_pkt(2'd1, 13'h056, 1'b0, 1'b0);
    send_pkt(2'd1, 13'h1FFF, 1'b0, 1'b0);
    send_pkt(2'd3, 13'h1FFF, 1'b1, 1'b1);
    send_pkt(2'd1, 13'h056, 1'b1, 1'b0);
    check_eq("chan1_after_null", 32'(cc_state[7:4]), 32'd6);
    stall_mode = 1'b0;
    noise_mode = 1'b0;

    // Channel 3 to CC 7, then a cc_skip request.
    for (int k = 0; k < 7; k++) send_pkt(2'd3, 13'h0777, 1'b0, 1'b0);
    check_eq("chan3_at7", 32'(cc_state[15:12]), 32'd7);
    send_pkt(2'd3, 13'h0777, 1'b1, 1'b1);
`ifdef TS_CC_ERR_INJECT_EN
    exp_c3 = 4'd9;
`else
    exp_c3 = 4'd8;
`endif
    check_eq("inject_cc_state", 32'(cc_state[15:12]), 32'(exp_c3));

    // Reset in the middle of the payload.
    queue_pkt(2'd0, 13'h123, 1'b0, 1'b0);
    start = 1'b1; chan = 2'd0; pid = 13'h123; pusi = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (pl_seq < 50 && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    check_eq("reach_byte50", 32'(pl_seq), 32'd50);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ts_data", 32'(ts_data), 32'h00);
    check_eq("mid_rst_ts_valid", 32'(ts_valid), 32'd0);
    check_eq("mid_rst_ts_sync", 32'(ts_sync), 32'd0);
    check_eq("mid_rst_pl_ready", 32'(pl_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_cc_state", 32'(cc_state), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_cc[i] = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // First packet after reset restarts at CC 0.
    send_pkt(2'd0, 13'h100, 1'b1, 1'b0);
    check_eq("post_rst_cc0", 32'(cc_state[3:0]), 32'd1);

    repeat (4) @(posedge clk);
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
